operand_sequencer: RTL and testbench
====================================

Name: operand_sequencer

Overview:
- Registered, parametrised successor to the combinational select-and-encode stage.
- Latches an instruction word and walks the requested register fields (Ra, Rb, Rc) one per bus cycle. Only one register drives the single shared bus per cycle.
- Then issues the destination register-in enable and signals completion.
- Sits between the control unit and the register file; also supplies the sign-extended immediate C.

Parameters:
- BITS, 32, instruction/data width
- OPC_BITS, 5, opcode field width at IR[BITS-1 -: OPC_BITS]
- REG_SEL, 4, width of each register field; Ra, Rb, Rc follow the opcode MSB-first
- NUM_REGS, 16, number of registers; must be <= 2**REG_SEL
- IMM_BITS, 19, immediate C width at IR[IMM_BITS-1:0]; overlaps Rc by design

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous, active-low reset
- start  in  1  begin a sequence; sampled only in IDLE
- ir  in  BITS  instruction word, latched on accepted start
- rd_mask  in  3  fields to read: bit0 Ra, bit1 Rb, bit2 Rc
- wr_sel  in  2  destination: 00 none, 01 Ra, 10 Rb, 11 Rc
- baout  in  1  base-address mode for Rb reads
- step  in  1  bus consumer accepted current read; advance
- wr_en  in  1  commit destination write
- busy  out  1  high in READ or WRITE
- done  out  1  one-cycle pulse in DONE
- reg_out_ctrl  out  NUM_REGS  one-hot register-out enable
- zero_out  out  1  drive constant 0 onto the bus instead of a register
- reg_in_ctrl  out  NUM_REGS  one-hot register-in enable
- cur_field  out  2  field being read: 01 Ra, 10 Rb, 11 Rc, 00 none
- c_sign_extended  out  BITS  IR[IMM_BITS-1:0] sign-extended to BITS
- range_err  out  1  sticky: a selected index >= NUM_REGS

Behaviour:
- Reset (clr low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including c_sign_extended and range_err.
  - All latched fields are cleared.
  - A reset mid-sequence aborts immediately; no done pulse is produced.
- States: IDLE, READ, WRITE, DONE. The state is binary-encoded.
- IDLE:
  - On start=1, latch ir, rd_mask, wr_sel and baout.
  - Register c_sign_extended from the latched ir.
  - Clear range_err.
  - Next state:
    - READ at the lowest set bit of rd_mask, if rd_mask != 0.
    - Otherwise WRITE, if wr_sel != 0.
    - Otherwise DONE.
- Latency: start accepted at edge k; the first read enable is valid after edge k and stays stable until the advancing edge.
- READ:
  - Drive reg_out_ctrl = one-hot(decoded field) and set cur_field.
  - When the field is Rb, baout=1 and Rb==0: drive zero_out=1 and reg_out_ctrl=0 (R0 reads as zero in base-address mode).
  - On step=1, go to the next higher set bit of the latched mask (order Ra, Rb, Rc). If none remain, go to WRITE when wr_sel != 0, else DONE.
  - With step=0, hold indefinitely.
- WRITE:
  - busy=1.
  - reg_in_ctrl = one-hot(destination) only in cycles where wr_en=1; otherwise 0.
  - Go to DONE on the edge where wr_en=1, so reg_in_ctrl is high for exactly one cycle.
- DONE: done=1 for one cycle; all enables are 0; return to IDLE.
- start while not in IDLE is ignored; the latched values are untouched.
- Out-of-range index (>= NUM_REGS): no enable bit is asserted, range_err is set, and sequencing proceeds normally.
- step and wr_en are ignored outside READ and WRITE respectively.
- c_sign_extended holds until the next accepted start.
- reg_out_ctrl, reg_in_ctrl and zero_out are never simultaneously nonzero. At most one bit of each one-hot output is set.
- All outputs are Moore functions of registered state, except reg_in_ctrl, which is gated by wr_en.

Test Plan:
- Reset then ir=0x1B068000, rd_mask=110, wr_sel=01, baout=0, start:
  - Cycle 1: cur_field=10, reg_out_ctrl=0x0001.
  - After step: cur_field=11, reg_out_ctrl=0x2000.
  - After step, with wr_en=1: reg_in_ctrl=0x0040 for one cycle.
  - Then done pulse.
  - c_sign_extended=0xFFFE8000 throughout.
- Same ir, rd_mask=010, baout=1: zero_out=1 and reg_out_ctrl=0 in READ; wr_sel=00 gives DONE right after step.
- rd_mask=000, wr_sel=00, start: DONE on the next cycle; done high for exactly 1 cycle; busy never high.
- Hold step=0 for 5 cycles in READ: reg_out_ctrl stays stable. Pulse start during this: no change to fields or sequence.
- Assert clr low mid-READ, asynchronously between edges: all outputs 0 immediately, state IDLE, no done. After release, a new start sequences correctly.
- NUM_REGS=8, Rc=1101 with rd_mask=100: reg_out_ctrl=0 and range_err=1. range_err is still set after DONE and clears on the next start.

Source files
------------

// File: rtl/operand_sequencer.sv
// Operand sequencer: latches an instruction, walks the requested register reads
// one per bus cycle over a shared bus, issues the destination write, then pulses done.
module operand_sequencer #(
  parameter int BITS     = 32,
  parameter int OPC_BITS = 5,
  parameter int REG_SEL  = 4,
  parameter int NUM_REGS = 16,
  parameter int IMM_BITS = 19
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [BITS-1:0]     ir,
  input  logic [2:0]          rd_mask,
  input  logic [1:0]          wr_sel,
  input  logic                baout,
  input  logic                step,
  input  logic                wr_en,
  output logic                busy,
  output logic                done,
  output logic [NUM_REGS-1:0] reg_out_ctrl,
  output logic                zero_out,
  output logic [NUM_REGS-1:0] reg_in_ctrl,
  output logic [1:0]          cur_field,
  output logic [BITS-1:0]     c_sign_extended,
  output logic                range_err
);

  localparam int RA_MSB = BITS - OPC_BITS - 1;
  localparam int RB_MSB = RA_MSB - REG_SEL;
  localparam int RC_MSB = RB_MSB - REG_SEL;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  state_t               state, nxt_state;
  logic [1:0]           cur, nxt_cur, nf, nxt_code, ws_q;
  logic [2:0]           mask_q;
  logic                 ba_q;
  logic [REG_SEL-1:0]   ra_q, rb_q, rc_q;
  logic [REG_SEL-1:0]   ra_src, rb_src, rc_src;
  logic [REG_SEL-1:0]   rd_idx, wr_idx, nxt_idx;
  logic [IMM_BITS-1:0]  imm_q;
  logic                 accept;
  logic                 unused_opc;

  // Lowest selected field strictly above 'after' (codes 1=Ra, 2=Rb, 3=Rc, 0=none).
  function automatic logic [1:0] next_field(input logic [2:0] mask, input logic [1:0] after);
    next_field = 2'd0;
    for (int i = 2; i >= 0; i--)
      if (mask[i] && (i + 1) > int'(after)) next_field = 2'(i + 1);
  endfunction

  function automatic logic [REG_SEL-1:0] pick(input logic [1:0] code,
                                              input logic [REG_SEL-1:0] a,
                                              input logic [REG_SEL-1:0] b,
                                              input logic [REG_SEL-1:0] c);
    case (code)
      2'd1:    pick = a;
      2'd2:    pick = b;
      2'd3:    pick = c;
      default: pick = '0;
    endcase
  endfunction

  function automatic logic in_range(input logic [REG_SEL-1:0] idx);
    in_range = int'(idx) < NUM_REGS;
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL-1:0] idx);
    onehot = in_range(idx) ? (NUM_REGS'(1) << idx) : '0;
  endfunction

  assign unused_opc = ^ir[BITS-1 -: OPC_BITS];
  assign accept     = (state == IDLE) && start;

  // On the accepting edge the range check must look at the incoming word, not the stale latch.
  assign ra_src = accept ? ir[RA_MSB -: REG_SEL] : ra_q;
  assign rb_src = accept ? ir[RB_MSB -: REG_SEL] : rb_q;
  assign rc_src = accept ? ir[RC_MSB -: REG_SEL] : rc_q;

  assign rd_idx   = pick(cur, ra_q, rb_q, rc_q);
  assign wr_idx   = pick(ws_q, ra_q, rb_q, rc_q);
  assign nxt_code = (nxt_state == READ)  ? nxt_cur :
                    (nxt_state == WRITE) ? (accept ? wr_sel : ws_q) : 2'd0;
  assign nxt_idx  = pick(nxt_code, ra_src, rb_src, rc_src);

  always_comb begin
    nxt_state = state;
    nxt_cur   = cur;
    nf        = 2'd0;
    case (state)
      IDLE: if (start) begin
        nf        = next_field(rd_mask, 2'd0);
        nxt_cur   = nf;
        nxt_state = (nf != 2'd0) ? READ : ((wr_sel != 2'd0) ? WRITE : DONE);
      end
      READ: if (step) begin
        nf        = next_field(mask_q, cur);
        nxt_cur   = nf;
        nxt_state = (nf != 2'd0) ? READ : ((ws_q != 2'd0) ? WRITE : DONE);
      end
      WRITE:   if (wr_en) nxt_state = DONE;
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      cur       <= 2'd0;
      mask_q    <= '0;
      ws_q      <= '0;
      ba_q      <= 1'b0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      imm_q     <= '0;
      range_err <= 1'b0;
    end else begin
      state <= nxt_state;
      cur   <= nxt_cur;
      if (accept) begin
        mask_q <= rd_mask;
        ws_q   <= wr_sel;
        ba_q   <= baout;
        ra_q   <= ir[RA_MSB -: REG_SEL];
        rb_q   <= ir[RB_MSB -: REG_SEL];
        rc_q   <= ir[RC_MSB -: REG_SEL];
        imm_q  <= ir[IMM_BITS-1:0];
      end
      range_err <= (range_err & ~accept) | ((nxt_code != 2'd0) && !in_range(nxt_idx));
    end
  end

  assign c_sign_extended = {{(BITS-IMM_BITS){imm_q[IMM_BITS-1]}}, imm_q};

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    reg_out_ctrl = '0;
    reg_in_ctrl  = '0;
    zero_out     = 1'b0;
    cur_field    = 2'd0;
    case (state)
      READ: begin
        busy      = 1'b1;
        cur_field = cur;
        // Base-address mode: R0 as a base reads as constant zero.
        if (cur == 2'd2 && ba_q && rb_q == '0) zero_out = 1'b1;
        else reg_out_ctrl = onehot(rd_idx);
      end
      WRITE: begin
        busy = 1'b1;
        if (wr_en) reg_in_ctrl = onehot(wr_idx);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed vector table, hand sequences and random stimulus
// against a phase-list reference model, on a 16-register and an 8-register instance.
module tb_operand_sequencer;

  logic        clk = 1'b0;
  logic        clr, start, baout, step, wr_en;
  logic [31:0] ir;
  logic [2:0]  rd_mask;
  logic [1:0]  wr_sel;

  logic        busy16, done16, zo16, rerr16;
  logic [15:0] ro16, ri16;
  logic [1:0]  cur16;
  logic [31:0] cse16;
  logic        busy8, done8, zo8, rerr8;
  logic [7:0]  ro8, ri8;
  logic [1:0]  cur8;
  logic [31:0] cse8;

  always #5 clk = ~clk;

  operand_sequencer #(.NUM_REGS(16)) dut16 (
    .clk(clk), .clr(clr), .start(start), .ir(ir), .rd_mask(rd_mask), .wr_sel(wr_sel),
    .baout(baout), .step(step), .wr_en(wr_en), .busy(busy16), .done(done16),
    .reg_out_ctrl(ro16), .zero_out(zo16), .reg_in_ctrl(ri16), .cur_field(cur16),
    .c_sign_extended(cse16), .range_err(rerr16));

  operand_sequencer #(.NUM_REGS(8)) dut8 (
    .clk(clk), .clr(clr), .start(start), .ir(ir), .rd_mask(rd_mask), .wr_sel(wr_sel),
    .baout(baout), .step(step), .wr_en(wr_en), .busy(busy8), .done(done8),
    .reg_out_ctrl(ro8), .zero_out(zo8), .reg_in_ctrl(ri8), .cur_field(cur8),
    .c_sign_extended(cse8), .range_err(rerr8));

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
  endtask

  // Reference model: pending phases (1..3 read field, 4 write, 5 done); empty = idle.
  int          ph[$];
  logic [3:0]  m_ra, m_rb, m_rc;
  logic [18:0] m_imm;
  logic [1:0]  m_ws;
  logic        m_ba, m_err16, m_err8;

  function automatic int fld(input int code);
    case (code)
      1:       return int'(m_ra);
      2:       return int'(m_rb);
      3:       return int'(m_rc);
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] oh(input int i, input int n);
    return (i < n) ? (16'd1 << i) : 16'd0;
  endfunction

  task automatic mreset();
    ph.delete();
    m_ra = 0; m_rb = 0; m_rc = 0; m_imm = 0; m_ws = 0; m_ba = 0;
    m_err16 = 0; m_err8 = 0;
  endtask

  task automatic enter();
    int i;
    if (ph.size() > 0 && ph[0] <= 4) begin
      i = (ph[0] == 4) ? fld(int'(m_ws)) : fld(ph[0]);
      if (i >= 16) m_err16 = 1;
      if (i >= 8)  m_err8  = 1;
    end
  endtask

  task automatic mapply();
    if (ph.size() == 0) begin
      if (start) begin
        m_ra = ir[26:23]; m_rb = ir[22:19]; m_rc = ir[18:15]; m_imm = ir[18:0];
        m_ws = wr_sel; m_ba = baout;
        for (int f = 1; f <= 3; f++) if (rd_mask[f-1]) ph.push_back(f);
        if (wr_sel != 0) ph.push_back(4);
        ph.push_back(5);
        m_err16 = 0; m_err8 = 0;
        enter();
      end
    end else begin
      case (ph[0])
        1, 2, 3: if (step)  begin void'(ph.pop_front()); enter(); end
        4:       if (wr_en) begin void'(ph.pop_front()); enter(); end
        default: void'(ph.pop_front());
      endcase
    end
  endtask

  task automatic check_all();
    int f;
    logic e_zo, rd;
    logic [31:0] e_cse;
    f     = (ph.size() > 0) ? ph[0] : 0;
    rd    = (f >= 1 && f <= 3);
    e_zo  = (f == 2) && m_ba && (m_rb == 0);
    e_cse = {{13{m_imm[18]}}, m_imm};
    chk("busy16", busy16, (f >= 1 && f <= 4));
    chk("done16", done16, (f == 5));
    chk("cur16",  cur16,  rd ? 2'(f) : 2'd0);
    chk("zo16",   zo16,   e_zo);
    chk("ro16",   ro16,   (rd && !e_zo) ? oh(fld(f), 16) : 16'd0);
    chk("ri16",   ri16,   (f == 4 && wr_en) ? oh(fld(int'(m_ws)), 16) : 16'd0);
    chk("cse16",  cse16,  e_cse);
    chk("rerr16", rerr16, m_err16);
    chk("busy8",  busy8,  (f >= 1 && f <= 4));
    chk("done8",  done8,  (f == 5));
    chk("zo8",    zo8,    e_zo);
    chk("ro8",    ro8,    (rd && !e_zo) ? oh(fld(f), 8) : 16'd0);
    chk("ri8",    ri8,    (f == 4 && wr_en) ? oh(fld(int'(m_ws)), 8) : 16'd0);
    chk("rerr8",  rerr8,  m_err8);
  endtask

  // Called at a negedge with inputs already set for the coming rising edge.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    if (!clr) mreset(); else mapply();
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic [31:0] w, input logic [2:0] m,
                       input logic [1:0] ws, input logic ba, input logic st, input logic we);
    start = s; ir = w; rd_mask = m; wr_sel = ws; baout = ba; step = st; wr_en = we;
  endtask

  typedef struct packed {
    logic        s;
    logic [31:0] w;
    logic [2:0]  m;
    logic [1:0]  ws;
    logic        ba, st, we;
    logic [1:0]  cur;
    logic [15:0] ro;
    logic        zo;
    logic [15:0] ri;
    logic        busy, done;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [2:0] m, input logic [1:0] ws,
                              input logic ba, input logic st, input logic we,
                              input logic [1:0] cur, input logic [15:0] ro, input logic zo,
                              input logic [15:0] ri, input logic busy, input logic done);
    vec_t v;
    v.s = s; v.w = 32'h1B06_8000; v.m = m; v.ws = ws; v.ba = ba; v.st = st; v.we = we;
    v.cur = cur; v.ro = ro; v.zo = zo; v.ri = ri; v.busy = busy; v.done = done;
    return v;
  endfunction

  localparam logic [31:0] T = 32'h1B06_8000;

  initial begin
    vec_t tbl[$];
    tbl.push_back(mk(1, 3'b110, 2'b01, 0, 0, 0, 2'd0, 16'h0000, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 2'd2, 16'h0001, 0, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 3'b000, 2'b00, 0, 1, 0, 2'd2, 16'h0001, 0, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 2'd3, 16'h2000, 0, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 3'b000, 2'b00, 0, 1, 0, 2'd3, 16'h2000, 0, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 2'd0, 16'h0000, 0, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 3'b000, 2'b00, 0, 0, 1, 2'd0, 16'h0000, 0, 16'h0040, 1, 0));
    tbl.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 2'd0, 16'h0000, 0, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 2'd0, 16'h0000, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(1, 3'b010, 2'b00, 1, 0, 0, 2'd0, 16'h0000, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 2'd2, 16'h0000, 1, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 3'b000, 2'b00, 0, 1, 0, 2'd2, 16'h0000, 1, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 2'd0, 16'h0000, 0, 16'h0000, 0, 1));
    tbl.push_back(mk(1, 3'b000, 2'b00, 0, 0, 0, 2'd0, 16'h0000, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 2'd0, 16'h0000, 0, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 2'd0, 16'h0000, 0, 16'h0000, 0, 0));

    clr = 1'b0;
    drive(0, 32'h0, 3'b000, 2'b00, 0, 0, 0);
    mreset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy16, 1'b0);
    chk("rst_cse",  cse16,  32'h0);
    chk("rst_rerr", rerr16, 1'b0);
    @(negedge clk);
    clr = 1'b1;

    // Directed vector table
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].s, tbl[i].w, tbl[i].m, tbl[i].ws, tbl[i].ba, tbl[i].st, tbl[i].we);
      #1;
      chk($sformatf("vec%0d", i), {cur16, ro16, zo16, ri16, busy16, done16},
          {tbl[i].cur, tbl[i].ro, tbl[i].zo, tbl[i].ri, tbl[i].busy, tbl[i].done});
      if (i >= 1) chk($sformatf("vec%0d_cse", i), cse16, 32'hFFFE_8000);
      tick();
    end

    // Stall in READ with a stray start pulse
    drive(1, T, 3'b110, 2'b01, 0, 0, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) drive(1, 32'h07FF_FFFF, 3'b001, 2'b11, 1, 0, 0);
      else        drive(0, T, 3'b000, 2'b00, 0, 0, 0);
      #1;
      chk("hold_ro",  ro16,  16'h0001);
      chk("hold_cur", cur16, 2'd2);
      tick();
    end
    drive(0, T, 3'b000, 2'b00, 0, 1, 0); tick();
    drive(0, T, 3'b000, 2'b00, 0, 1, 0); tick();
    drive(0, T, 3'b000, 2'b00, 0, 0, 1);
    #1;
    chk("hold_ri",  ri16,  16'h0040);
    chk("hold_cse", cse16, 32'hFFFE_8000);
    tick();
    drive(0, T, 3'b000, 2'b00, 0, 0, 0); tick();

    // Asynchronous clear in the middle of a read
    drive(1, T, 3'b001, 2'b11, 0, 0, 0); tick();
    drive(0, T, 3'b000, 2'b00, 0, 0, 0);
    #3 clr = 1'b0;
    #1;
    chk("aclr_out", {busy16, done16, ro16, zo16, ri16, cur16, rerr16}, 38'h0);
    chk("aclr_cse", cse16, 32'h0);
    mreset();
    @(negedge clk);
    tick();
    tick();
    clr = 1'b1;
    drive(1, T, 3'b001, 2'b11, 0, 0, 0); tick();
    drive(0, T, 3'b000, 2'b00, 0, 0, 0);
    #1 chk("aclr_ra", ro16, 16'h0040);
    tick();
    drive(0, T, 3'b000, 2'b00, 0, 1, 0); tick();
    drive(0, T, 3'b000, 2'b00, 0, 0, 1); tick();
    drive(0, T, 3'b000, 2'b00, 0, 0, 0); tick();
    tick();

    // Out-of-range Rc on the 8-register instance
    drive(1, T, 3'b100, 2'b00, 0, 0, 0); tick();
    drive(0, T, 3'b000, 2'b00, 0, 0, 0);
    #1;
    chk("oor_ro8",   ro8,   8'h00);
    chk("oor_err8",  rerr8, 1'b1);
    chk("oor_ro16",  ro16,  16'h2000);
    tick();
    drive(0, T, 3'b000, 2'b00, 0, 1, 0); tick();
    drive(0, T, 3'b000, 2'b00, 0, 0, 0); tick();
    #1 chk("oor_sticky", rerr8, 1'b1);
    drive(1, 32'h0, 3'b001, 2'b00, 0, 0, 0); tick();
    drive(0, 32'h0, 3'b000, 2'b00, 0, 0, 0);
    #1 chk("oor_clear", rerr8, 1'b0);
    tick();
    drive(0, 32'h0, 3'b000, 2'b00, 0, 1, 0); tick();
    drive(0, 32'h0, 3'b000, 2'b00, 0, 0, 0); tick();
    tick();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w[22:19] = 4'd0;
      drive(($urandom_range(0, 2) == 0), w, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    drive(0, 32'h0, 3'b000, 2'b00, 0, 1, 1);
    repeat (6) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
